// File: rtl/wallclock_pkg.sv
// Shared constants and types for the wallclock time registers and their update arbiter.
// Grant bit positions, BCD digit limits and a small BCD-to-binary helper.
package wallclock_pkg;

  localparam int G_HOUR = 0;
  localparam int G_MIN  = 1;
  localparam int G_TICK = 2;
  localparam int G_LOAD = 3;

  localparam logic [3:0] DIGIT_MAX       = 4'd9;
  localparam logic [3:0] M2_MAX          = 4'd5;
  localparam logic [3:0] H2_MAX          = 4'd2;
  localparam logic [3:0] H1_MAX_AT_H2MAX = 4'd3;
  localparam logic [5:0] SEC_MAX         = 6'd59;

  typedef struct packed {
    logic [3:0] h2;
    logic [3:0] h1;
    logic [3:0] m2;
    logic [3:0] m1;
    logic [5:0] secs;
  } wall_time_t;

  // tens*10 + ones, built from shifts so it stays a narrow adder
  function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    return ({3'b000, tens} << 3) + ({3'b000, tens} << 1) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/bcd_time_next.sv
// Combinational next-time function: given the current time and the one-hot grant,
// produce the time to be registered next cycle, plus the validity of the pending load digits.
module bcd_time_next
  import wallclock_pkg::*;
#(
  parameter int HOUR_MAX = 23,
  parameter int MIN_MAX  = 59
) (
  input  logic [3:0] cur_h2,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_m2,
  input  logic [3:0] cur_m1,
  input  logic [5:0] cur_secs,
  input  logic [3:0] grant,
  input  logic [3:0] ld_h2,
  input  logic [3:0] ld_h1,
  input  logic [3:0] ld_m2,
  input  logic [3:0] ld_m1,
  output logic [3:0] nxt_h2,
  output logic [3:0] nxt_h1,
  output logic [3:0] nxt_m2,
  output logic [3:0] nxt_m1,
  output logic [5:0] nxt_secs,
  output logic       load_valid
);

  wall_time_t cur;
  wall_time_t nxt;
  logic [3:0] min_m2;
  logic [3:0] min_m1;
  logic       min_wrap;
  logic [3:0] hour_h2;
  logic [3:0] hour_h1;
  logic       digits_bcd;
  logic       hour_ok;

  assign cur = '{h2: cur_h2, h1: cur_h1, m2: cur_m2, m1: cur_m1, secs: cur_secs};

  // Minute increment with wrap at MIN_MAX; min_wrap drives the hour carry on a tick
  always_comb begin
    min_m2   = cur.m2;
    min_m1   = cur.m1 + 4'd1;
    min_wrap = 1'b0;
    if (bcd_to_bin(cur.m2, cur.m1) >= 7'(MIN_MAX)) begin
      min_m2   = '0;
      min_m1   = '0;
      min_wrap = 1'b1;
    end else if (cur.m1 >= DIGIT_MAX) begin
      min_m2 = cur.m2 + 4'd1;
      min_m1 = '0;
    end
  end

  always_comb begin
    hour_h2 = cur.h2;
    hour_h1 = cur.h1 + 4'd1;
    if (bcd_to_bin(cur.h2, cur.h1) >= 7'(HOUR_MAX)) begin
      hour_h2 = '0;
      hour_h1 = '0;
    end else if (cur.h1 >= DIGIT_MAX) begin
      hour_h2 = cur.h2 + 4'd1;
      hour_h1 = '0;
    end
  end

  assign digits_bcd = (ld_h2 <= DIGIT_MAX) && (ld_h1 <= DIGIT_MAX) &&
                      (ld_m2 <= DIGIT_MAX) && (ld_m1 <= DIGIT_MAX);
  assign hour_ok    = (ld_h2 <= H2_MAX) &&
                      !((ld_h2 == H2_MAX) && (ld_h1 > H1_MAX_AT_H2MAX)) &&
                      (bcd_to_bin(ld_h2, ld_h1) <= 7'(HOUR_MAX));
  assign load_valid = digits_bcd && hour_ok && (ld_m2 <= M2_MAX);

  always_comb begin
    nxt = cur;
    if (grant[G_LOAD]) begin
      if (load_valid) begin
        nxt.h2   = ld_h2;
        nxt.h1   = ld_h1;
        nxt.m2   = ld_m2;
        nxt.m1   = ld_m1;
        nxt.secs = '0;
      end
    end else if (grant[G_TICK]) begin
      if (cur.secs >= SEC_MAX) begin
        nxt.secs = '0;
        nxt.m2   = min_m2;
        nxt.m1   = min_m1;
        if (min_wrap) begin
          nxt.h2 = hour_h2;
          nxt.h1 = hour_h1;
        end
      end else begin
        nxt.secs = cur.secs + 6'd1;
      end
    end else if (grant[G_MIN]) begin
      nxt.m2 = min_m2;
      nxt.m1 = min_m1;
    end else if (grant[G_HOUR]) begin
      nxt.h2 = hour_h2;
      nxt.h1 = hour_h1;
    end
  end

  assign nxt_h2   = nxt.h2;
  assign nxt_h1   = nxt.h1;
  assign nxt_m2   = nxt.m2;
  assign nxt_m1   = nxt.m1;
  assign nxt_secs = nxt.secs;

endmodule

// File: rtl/time_update_arbiter.sv
// Owns the wallclock time registers and serialises every write to them: requests land in
// pending slots and one fixed-priority winner (load > tick > min > hour) is applied per cycle.
module time_update_arbiter
  import wallclock_pkg::*;
#(
  parameter int TICK_QDEPTH = 3,
  parameter int HOUR_MAX    = 23,
  parameter int MIN_MAX     = 59
) (
  input  logic       CLK100MHZ,
  input  logic       RESET,
  input  logic       sec_tick,
  input  logic       inc_min_req,
  input  logic       inc_hour_req,
  input  logic       load_req,
  input  logic [3:0] ld_h2,
  input  logic [3:0] ld_h1,
  input  logic [3:0] ld_m2,
  input  logic [3:0] ld_m1,
  output logic [3:0] hours2,
  output logic [3:0] hours1,
  output logic [3:0] mins2,
  output logic [3:0] mins1,
  output logic [5:0] secs,
  output logic [3:0] grant,
  output logic       overrun,
  output logic       load_err
);

  localparam int CW = $clog2(TICK_QDEPTH + 1);
  localparam logic [CW-1:0] TICK_FULL = CW'(TICK_QDEPTH);

  logic [CW-1:0] tick_cnt_reg,  tick_cnt_next;
  logic          min_pend_reg,  min_pend_next;
  logic          hour_pend_reg, hour_pend_next;
  logic          load_pend_reg, load_pend_next;
  logic [15:0]   ld_reg,        ld_next;
  logic          overrun_reg,   overrun_next;
  logic [3:0]    h2_reg, h1_reg, m2_reg, m1_reg;
  logic [5:0]    secs_reg;

  logic [3:0] h2_next, h1_next, m2_next, m1_next;
  logic [5:0] secs_next;
  logic       load_valid;
  logic       load_ok;
  logic       tick_drop;
  logic       min_consumed, hour_consumed;
  logic       min_merge, hour_merge, load_merge;

  // Grant depends only on registered slots, so it never sees same-cycle request pulses
  always_comb begin
    grant = '0;
    if (load_pend_reg)
      grant[G_LOAD] = 1'b1;
    else if (tick_cnt_reg != '0)
      grant[G_TICK] = 1'b1;
    else if (min_pend_reg)
      grant[G_MIN] = 1'b1;
    else if (hour_pend_reg)
      grant[G_HOUR] = 1'b1;
  end

  bcd_time_next #(
    .HOUR_MAX (HOUR_MAX),
    .MIN_MAX  (MIN_MAX)
  ) u_next (
    .cur_h2     (h2_reg),
    .cur_h1     (h1_reg),
    .cur_m2     (m2_reg),
    .cur_m1     (m1_reg),
    .cur_secs   (secs_reg),
    .grant      (grant),
    .ld_h2      (ld_reg[15:12]),
    .ld_h1      (ld_reg[11:8]),
    .ld_m2      (ld_reg[7:4]),
    .ld_m1      (ld_reg[3:0]),
    .nxt_h2     (h2_next),
    .nxt_h1     (h1_next),
    .nxt_m2     (m2_next),
    .nxt_m1     (m1_next),
    .nxt_secs   (secs_next),
    .load_valid (load_valid)
  );

  assign load_ok  = grant[G_LOAD] & load_valid;
  assign load_err = grant[G_LOAD] & ~load_valid;

  // Tick queue: simultaneous request and grant cancel out; a full queue drops the tick
  always_comb begin
    tick_cnt_next = tick_cnt_reg;
    tick_drop     = 1'b0;
    if (sec_tick && !grant[G_TICK]) begin
      if (tick_cnt_reg == TICK_FULL)
        tick_drop = 1'b1;
      else
        tick_cnt_next = tick_cnt_reg + 1'b1;
    end else if (!sec_tick && grant[G_TICK]) begin
      tick_cnt_next = tick_cnt_reg - 1'b1;
    end
  end

  // A valid load supersedes any queued button presses; a fresh press in that cycle still lands
  always_comb begin
    min_consumed   = grant[G_MIN] | load_ok;
    hour_consumed  = grant[G_HOUR] | load_ok;
    min_merge      = inc_min_req & min_pend_reg & ~min_consumed;
    hour_merge     = inc_hour_req & hour_pend_reg & ~hour_consumed;
    load_merge     = load_req & load_pend_reg & ~grant[G_LOAD];
    min_pend_next  = inc_min_req | (min_pend_reg & ~min_consumed);
    hour_pend_next = inc_hour_req | (hour_pend_reg & ~hour_consumed);
    load_pend_next = load_req | (load_pend_reg & ~grant[G_LOAD]);
    ld_next        = load_req ? {ld_h2, ld_h1, ld_m2, ld_m1} : ld_reg;
    overrun_next   = overrun_reg | tick_drop | min_merge | hour_merge | load_merge;
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      tick_cnt_reg  <= '0;
      min_pend_reg  <= 1'b0;
      hour_pend_reg <= 1'b0;
      load_pend_reg <= 1'b0;
      ld_reg        <= '0;
      overrun_reg   <= 1'b0;
      h2_reg        <= '0;
      h1_reg        <= '0;
      m2_reg        <= '0;
      m1_reg        <= '0;
      secs_reg      <= '0;
    end else begin
      tick_cnt_reg  <= tick_cnt_next;
      min_pend_reg  <= min_pend_next;
      hour_pend_reg <= hour_pend_next;
      load_pend_reg <= load_pend_next;
      ld_reg        <= ld_next;
      overrun_reg   <= overrun_next;
      h2_reg        <= h2_next;
      h1_reg        <= h1_next;
      m2_reg        <= m2_next;
      m1_reg        <= m1_next;
      secs_reg      <= secs_next;
    end
  end

  assign hours2  = h2_reg;
  assign hours1  = h1_reg;
  assign mins2   = m2_reg;
  assign mins1   = m1_reg;
  assign secs    = secs_reg;
  assign overrun = overrun_reg;

endmodule
